// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one async_transmitter
// between NREQ byte sources using a valid/ready handshake per requester.
// Optional build macro UART_TX_ARB_TAG_EN: every grant sends a header byte
// (8'hA0 | grant_id) before the data byte.
//
// Handshake: a requester holds req_valid[i] and its byte steady until it sees
// req_ready[i]. req_ready[i] is a one-cycle pulse meaning "byte taken". A
// request withdrawn before that pulse leaves no trace.
//
// Timing: the grant decision is made in an IDLE cycle. req_ready pulses in
// the following cycle, while the FSM is in START. TxD_start pulses in the
// cycle after that. When TxD_start is high, TxD_data already holds the byte,
// and it stays unchanged until the frame ends.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int BUSY_TIMEOUT = 16,
  parameter int IDW          = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              TxD_start,
  output logic [7:0]        TxD_data,
  input  logic              TxD_busy,
  output logic [IDW-1:0]    grant_id,
  output logic              active,
  output logic              timeout_err
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    HDR_START,
    HDR_WAIT_BUSY,
    HDR_WAIT_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic              start_q, start_d;
  logic [7:0]        txd_data_q, txd_data_d;
  logic [IDW-1:0]    grant_q, grant_d;
  logic              terr_q, terr_d;
`ifdef UART_TX_ARB_TAG_EN
  logic [7:0]        byte_q, byte_d;
`endif

  logic              found;
  logic [IDW-1:0]    win;
  logic [IDW:0]      scan;
  logic [7:0]        win_data;

  // Round-robin search: first valid requester after rr_q, wrapping modulo NREQ.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan     = '0;
    win_data = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan = {1'b0, rr_q} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NREQ)) scan = scan - (IDW+1)'(NREQ);
      if (!found && req_valid[scan[IDW-1:0]]) begin
        found = 1'b1;
        win   = scan[IDW-1:0];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) win_data = req_data[8*i +: 8];
    end
  end

  // Next-state and registered-output logic.
  // The header states reuse the start/timeout rules of the data frame.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    req_ready_d = '0;
    start_d     = 1'b0;
    txd_data_d  = txd_data_q;
    grant_d     = grant_q;
    terr_d      = 1'b0;
`ifdef UART_TX_ARB_TAG_EN
    byte_d      = byte_q;
`endif
    case (state_q)
      IDLE: begin
        // A busy transmitter (foreign use or stale frame) blocks granting.
        if (!TxD_busy && found) begin
          for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) req_ready_d[i] = 1'b1;
          end
          grant_d = win;
          rr_d    = win;
`ifdef UART_TX_ARB_TAG_EN
          txd_data_d = 8'hA0 | 8'(win);
          byte_d     = win_data;
          state_d    = HDR_START;
`else
          txd_data_d = win_data;
          state_d    = START;
`endif
        end
      end
`ifdef UART_TX_ARB_TAG_EN
      HDR_START: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = HDR_WAIT_BUSY;
      end
      HDR_WAIT_BUSY: begin
        if (TxD_busy) begin
          state_d = HDR_WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT)) begin
          // A header timeout drops the data byte as well.
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HDR_WAIT_DONE: begin
        if (!TxD_busy) begin
          txd_data_d = byte_q;
          state_d    = START;
        end
      end
`endif
      START: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (TxD_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT)) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!TxD_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. A synchronous reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= IDW'(NREQ - 1);
      cnt_q       <= '0;
      req_ready_q <= '0;
      start_q     <= 1'b0;
      txd_data_q  <= 8'h00;
      grant_q     <= '0;
      terr_q      <= 1'b0;
`ifdef UART_TX_ARB_TAG_EN
      byte_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      start_q     <= start_d;
      txd_data_q  <= txd_data_d;
      grant_q     <= grant_d;
      terr_q      <= terr_d;
`ifdef UART_TX_ARB_TAG_EN
      byte_q      <= byte_d;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign TxD_start   = start_q;
  assign TxD_data    = txd_data_q;
  assign grant_id    = grant_q;
  assign timeout_err = terr_q;
  assign active      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. It contains a transmitter stub and requester
// drivers, and checks results against a scoreboard of expected
// {first, grant_id, byte} frames.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int BT    = 16;
  localparam int FRAME = 10;
  localparam int ENTW  = IDW + 9;
  localparam int FIRST = IDW + 8;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              TxD_start;
  logic [7:0]        TxD_data;
  logic              TxD_busy;
  logic [IDW-1:0]    grant_id;
  logic              active;
  logic              timeout_err;

  uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(BT), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .TxD_start(TxD_start), .TxD_data(TxD_data),
    .TxD_busy(TxD_busy), .grant_id(grant_id), .active(active),
    .timeout_err(timeout_err)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state
  logic [ENTW-1:0] exp_q[$];
  int              n_checks = 0;
  int              n_errors = 0;
  int              cyc = 0;
  int              ready_cyc = 0;
  int              start_cyc = 0;
  int              acc_count = 0;
  int              to_count = 0;
  int              busy_cnt = 0;
  int              tb_rr = NREQ - 1;
  logic            stub = 1'b0;
  logic            to_expect = 1'b0;
  logic            frame_chk = 1'b0;
  logic [7:0]      cur_byte = 8'h00;
  logic [NREQ-1:0] prev_ready = '0;
  logic            prev_start = 1'b0;
  logic [NREQ-1:0] auto_drop = '1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: monitors and the transmitter stub run on the falling edge.
  task automatic step();
    logic [ENTW-1:0] e;
    logic [NREQ-1:0] oh;
    @(negedge clk);
    cyc++;
    if (req_ready != '0) begin
      // TxD_busy still holds the value the DUT sampled at the grant edge.
      check("grant_busy_free", 32'(TxD_busy), 32'(0));
      check("ready_1cyc", 32'(prev_ready & req_ready), 32'(0));
      if (exp_q.size() == 0) begin
        check("ready_expected", 32'(0), 32'(1));
      end else begin
        oh = '0;
        oh[exp_q[0][IDW+7:8]] = 1'b1;
        check("ready_onehot", 32'(req_ready), 32'(oh));
      end
      ready_cyc = cyc;
      acc_count++;
      req_valid = req_valid & ~(req_ready & auto_drop);
    end
    prev_ready = req_ready;
    if (TxD_start) begin
      check("start_1cyc", 32'(prev_start), 32'(0));
      if (exp_q.size() == 0) begin
        check("start_expected", 32'(0), 32'(1));
      end else begin
        e = exp_q.pop_front();
        check("txd_data", 32'(TxD_data), 32'(e[7:0]));
        check("grant_id", 32'(grant_id), 32'(e[IDW+7:8]));
        if (e[FIRST]) check("start_lat", 32'(cyc - ready_cyc), 32'(1));
        cur_byte = e[7:0];
      end
      start_cyc = cyc;
      frame_chk = 1'b1;
      if (!stub) busy_cnt = FRAME;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0 && frame_chk) begin
        check("data_stable", 32'(TxD_data), 32'(cur_byte));
        frame_chk = 1'b0;
      end
    end
    prev_start = TxD_start;
    TxD_busy = (busy_cnt > 0);
    if (timeout_err === 1'b1) begin
      check("to_expected", 32'(to_expect), 32'(1));
      check("to_lat", 32'(cyc - start_cyc), 32'(BT + 1));
      to_count++;
      while (exp_q.size() > 0 && !exp_q[0][FIRST]) void'(exp_q.pop_front());
    end
  endtask

  // driver tasks
  task automatic set_req(input int id, input logic [7:0] b);
    req_data[8*id +: 8] = b;
    req_valid[id] = 1'b1;
  endtask

  task automatic expect_grant(input int id, input logic [7:0] b);
`ifdef UART_TX_ARB_TAG_EN
    exp_q.push_back({1'b1, IDW'(id), 8'hA0 | 8'(id)});
    exp_q.push_back({1'b0, IDW'(id), b});
`else
    exp_q.push_back({1'b1, IDW'(id), b});
`endif
    tb_rr = id;
  endtask

  // All bits of mask raised together and dropped on accept: served in
  // ascending order starting after the last winner.
  task automatic expect_mask(input logic [NREQ-1:0] mask);
    int base;
    int idx;
    base = tb_rr;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (base + k) % NREQ;
      if (mask[idx]) expect_grant(idx, req_data[8*idx +: 8]);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_txd_start", 32'(TxD_start), 32'(0));
    check("rst_txd_data", 32'(TxD_data), 32'(0));
    check("rst_grant_id", 32'(grant_id), 32'(0));
    check("rst_active", 32'(active), 32'(0));
    check("rst_timeout_err", 32'(timeout_err), 32'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    check_reset_vals();
    rst_n = 1'b1;
    exp_q.delete();
    frame_chk = 1'b0;
    tb_rr = NREQ - 1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !active && !TxD_busy && req_valid == '0) && n < 600) begin
      step();
      n++;
    end
    if (n >= 600) check(tag, 32'(0), 32'(1));
    step();
  endtask

  initial begin
    int acc0;
    int n;
    logic [NREQ-1:0] mask;
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    TxD_busy = 1'b0;
    repeat (3) step();
    do_reset();

    // single requester
    set_req(2, 8'h5A);
    expect_grant(2, 8'h5A);
    wait_idle("wait_single");

    // round robin from reset: 0,1,2,3 then 0 again
    do_reset();
    set_req(0, 8'h11); set_req(1, 8'h22); set_req(2, 8'h33); set_req(3, 8'h44);
    expect_mask(4'b1111);
    wait_idle("wait_rr");
    set_req(0, 8'h11);
    expect_grant(0, 8'h11);
    wait_idle("wait_rr_again");

    // fairness: req0 stays asserted across accepts, req2 must come second
    do_reset();
    auto_drop = 4'b1110;
    set_req(0, 8'hE0); set_req(2, 8'hE2);
    expect_grant(0, 8'hE0);
    expect_grant(2, 8'hE2);
    expect_grant(0, 8'hE0);
    acc0 = acc_count;
    n = 0;
    while (acc_count < acc0 + 3 && n < 400) begin step(); n++; end
    if (n >= 400) check("wait_fair", 32'(0), 32'(1));
    req_valid[0] = 1'b0;
    auto_drop = '1;
    wait_idle("wait_fair_idle");

    // timeout: transmitter never raises busy
    stub = 1'b1;
    to_expect = 1'b1;
    set_req(1, 8'h77);
    expect_grant(1, 8'h77);
    n = 0;
    while (to_count == 0 && n < 200) begin step(); n++; end
    check("to_seen", 32'(to_count), 32'(1));
    stub = 1'b0;
    to_expect = 1'b0;
    wait_idle("wait_to_idle");
    set_req(3, 8'h3C);
    expect_grant(3, 8'h3C);
    wait_idle("wait_after_to");

    // random request masks and bytes
    for (int r = 0; r < 4; r++) begin
      mask = NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        if (mask[i]) set_req(i, 8'($urandom_range(0, 255)));
      end
      expect_mask(mask);
      wait_idle("wait_rand");
    end

    // reset mid-frame: pointer returns to NREQ-1 so requester 0 wins first
    set_req(1, 8'h9D);
    expect_grant(1, 8'h9D);
    n = 0;
    while (busy_cnt == 0 && n < 50) begin step(); n++; end
    if (n >= 50) check("wait_busy_mid", 32'(0), 32'(1));
    repeat (3) step();
    set_req(0, 8'hA1);
    set_req(3, 8'hB3);
    do_reset();
    check("busy_held_after_rst", 32'(TxD_busy), 32'(1));
    expect_mask(4'b1001);
    wait_idle("wait_mid_rst");

    // single tagged/untagged grant: exactly one accept pulse
    acc0 = acc_count;
    set_req(3, 8'hC3);
    expect_grant(3, 8'hC3);
    wait_idle("wait_tag");
    check("tag_ready_once", 32'(acc_count - acc0), 32'(1));

    check("queue_empty", 32'(exp_q.size()), 32'(0));
    check("to_total", 32'(to_count), 32'(1));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter sharing one async_transmitter between NREQ byte sources. Each requester offers a byte with a valid/ready handshake. The arbiter grants one requester, latches its byte, pulses TxD_start and tracks TxD_busy until the frame completes. It sits between the on-chip byte producers and the transmitter's TxD_start/TxD_data/TxD_busy interface.

Parameters:
NREQ, 4, number of requesters (2..16)
BUSY_TIMEOUT, 16, clk cycles allowed after TxD_start for TxD_busy to rise
IDW, 2, width of grant_id (= clog2(NREQ); set by the instantiating module)

Ports:
clk  input  1  system clock; all logic on its rising edge
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
req_valid  input  NREQ  bit i: requester i has a byte pending
req_data  input  8*NREQ  byte of requester i at bits [8i+7:8i]
req_ready  output  NREQ  one-cycle pulse on bit i: requester i's byte accepted
TxD_start  output  1  one-cycle start pulse to the transmitter
TxD_data  output  8  byte to the transmitter; stable from start pulse to frame end
TxD_busy  input  1  transmitter busy flag
grant_id  output  IDW  index of the requester currently being served
active  output  1  high while any state other than IDLE
timeout_err  output  1  one-cycle pulse when TxD_busy fails to rise within BUSY_TIMEOUT

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; req_ready=0, TxD_start=0, TxD_data=8'h00, grant_id=0, active=0, timeout_err=0; rr pointer=NREQ-1, so requester 0 has highest priority first. Reset mid-frame aborts at once; the latched byte is discarded. The transmitter itself is not reset by this block.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE: grant only if TxD_busy=0 and any req_valid=1.
  - Winner: first set bit searching from rr+1 upward, wrapping modulo NREQ.
  - On the grant edge: req_ready[winner]=1 for exactly that cycle; latch TxD_data=req_data[winner]; grant_id=winner; rr=winner; go to START.
- START: TxD_start=1 for exactly one cycle; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - TxD_busy=1 -> WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT: timeout_err=1 for one cycle, byte dropped, go to IDLE.
- WAIT_DONE: stay while TxD_busy=1; on TxD_busy=0 go to IDLE.
- Earliest next grant: first IDLE cycle. Minimum spacing between req_ready pulses equals the frame time plus 3 cycles.
- Requesters must hold req_valid and req_data until they see req_ready. Dropping req_valid before grant withdraws the request, with no side effects.
- Simultaneous requests resolve by rr order only. A requester re-asserting immediately is served after every other pending requester.
- TxD_busy=1 in IDLE (foreign use or a stale frame) blocks granting; no error is raised.
- req_valid changes during START/WAIT_* are ignored until the return to IDLE.
- active=1 in START, WAIT_BUSY and WAIT_DONE; it also covers the HDR states below when present.

Optional Feature:
Macro UART_TX_ARB_TAG_EN.
- Defined: each grant sends two frames. First a header byte 8'hA0 | grant_id, then the data byte.
- Added states: HDR_START and HDR_WAIT_BUSY/HDR_WAIT_DONE, inserted before START with identical timing and timeout rules. TxD_data=header during the header frame, then the latched data byte.
- A timeout on the header drops both bytes. req_ready still pulses on the grant edge.
- Undefined: one frame per grant, exactly as above.

Test Plan:
- Single: req_valid=4'b0100, req_data[23:16]=8'h5A -> req_ready=4'b0100 for 1 cycle; TxD_start pulse 2 cycles after grant; TxD_data=8'h5A; UART decoder reads 5A with parity=~^8'h5A=1.
- Round-robin: all four valid with bytes 11,22,33,44, held -> bytes decoded in order 11,22,33,44, then 11 again; grant_id sequence 0,1,2,3,0.
- Fairness: req0 re-asserts right after every accept while req2 is pending -> req2 served second, not starved.
- Timeout: TxD_busy stubbed to 0 -> timeout_err pulses exactly BUSY_TIMEOUT+1 cycles after TxD_start; return to IDLE; next request granted.
- Reset mid-frame: rst_n=0 for 1 cycle in WAIT_DONE -> all outputs at reset values next edge; after TxD_busy drops, requester 0 is granted first.
- With UART_TX_ARB_TAG_EN: req3 sends 8'hC3 -> decoder receives A3 then C3; req_ready[3] pulses once.
